// File: rtl/microcode_sequencer.sv
// microcode_sequencer: walks a per-opcode microprogram held in an external
// synchronous ROM addressed by {opcode, step}. Each ROM word is either a
// micro-op to issue, a wait on a completion flag, a clock halt, or the end
// marker. Optional build macro MICROSEQ_WAIT_TIMEOUT_EN adds a watchdog that
// aborts a WAIT after TIMEOUT_CYCLES cycles without its flag.
module microcode_sequencer #(
    parameter int OPCODE_W       = 8,
    parameter int STEP_W         = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         op_valid,
    input  logic [OPCODE_W-1:0]          opcode,
    output logic                         ready,
    output logic [OPCODE_W+STEP_W-1:0]   rom_addr,
    input  logic [5:0]                   rom_data,
    output logic [5:0]                   uop,
    output logic                         uop_valid,
    input  logic                         mt_done,
    input  logic                         ut_done,
    input  logic                         ft_done,
    input  logic                         dd_done,
    input  logic                         gpu_done,
    output logic                         halted,
    input  logic                         resume,
    output logic                         err
);

    localparam logic [5:0] ENDMICRO   = 6'd0;
    localparam logic [5:0] HLT_CLK    = 6'd32;
    localparam logic [5:0] WAIT_CYCLE = 6'd36;
    localparam logic [5:0] WAIT_MT    = 6'd41;
    localparam logic [5:0] WAIT_UT    = 6'd42;
    localparam logic [5:0] WAIT_FT    = 6'd43;
    localparam logic [5:0] WAIT_DD    = 6'd44;
    localparam logic [5:0] WAIT_GPU   = 6'd45;
    localparam logic [5:0] LAST_UOP   = 6'd46;

    // A zero timeout would make every WAIT abort before it could observe a flag.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_WAIT, S_HALT} state_t;

    state_t              state;
    logic [OPCODE_W-1:0] op_q;
    logic [STEP_W-1:0]   step_q;
    logic [STEP_W-1:0]   step_nxt;
    logic                step_wrap;
    logic [5:0]          wait_kind;
    logic                is_wait;
    logic                flag_hit;

`ifdef MICROSEQ_WAIT_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] wait_cnt;
`endif

    assign ready     = (state == S_IDLE);
    assign rom_addr  = {op_q, step_q};
    assign step_nxt  = step_q + 1'b1;
    // Advancing from the last step would wrap onto step 0 of the same opcode.
    assign step_wrap = &step_q;

    // Classify the ROM word currently seen in DECODE as a wait kind.
    always_comb begin
        is_wait = 1'b0;
        case (rom_data)
            WAIT_CYCLE, WAIT_MT, WAIT_UT, WAIT_FT, WAIT_DD, WAIT_GPU: is_wait = 1'b1;
            default: is_wait = 1'b0;
        endcase
    end

    // Select the completion flag that releases the latched wait kind.
    always_comb begin
        flag_hit = 1'b0;
        case (wait_kind)
            WAIT_CYCLE: flag_hit = 1'b1;
            WAIT_MT:    flag_hit = mt_done;
            WAIT_UT:    flag_hit = ut_done;
            WAIT_FT:    flag_hit = ft_done;
            WAIT_DD:    flag_hit = dd_done;
            WAIT_GPU:   flag_hit = gpu_done;
            default:    flag_hit = 1'b0;
        endcase
    end

    // Sequencer FSM with registered issue, halt and error outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            op_q      <= '0;
            step_q    <= '0;
            wait_kind <= ENDMICRO;
            uop       <= ENDMICRO;
            uop_valid <= 1'b0;
            halted    <= 1'b0;
            err       <= 1'b0;
`ifdef MICROSEQ_WAIT_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
        end else begin
            uop_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (op_valid) begin
                        op_q   <= opcode;
                        step_q <= '0;
                        state  <= S_FETCH;
                    end
                end
                // ROM is reading {op_q, step_q}; its word is valid next cycle.
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    if (rom_data == ENDMICRO) begin
                        state <= S_IDLE;
                    end else if (rom_data == HLT_CLK) begin
                        uop       <= rom_data;
                        uop_valid <= 1'b1;
                        halted    <= 1'b1;
                        state     <= S_HALT;
                    end else if (is_wait) begin
                        wait_kind <= rom_data;
                        state     <= S_WAIT;
`ifdef MICROSEQ_WAIT_TIMEOUT_EN
                        wait_cnt  <= '0;
`endif
                    end else if (rom_data <= LAST_UOP) begin
                        uop       <= rom_data;
                        uop_valid <= 1'b1;
                        state     <= step_wrap ? S_IDLE : S_FETCH;
                        step_q    <= step_wrap ? step_q : step_nxt;
                        if (step_wrap) err <= 1'b1;
                    end else begin
                        // Word outside the micro-op encoding: abort the opcode.
                        err   <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (flag_hit) begin
                        state  <= step_wrap ? S_IDLE : S_FETCH;
                        step_q <= step_wrap ? step_q : step_nxt;
                        if (step_wrap) err <= 1'b1;
                    end
`ifdef MICROSEQ_WAIT_TIMEOUT_EN
                    else if (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        err   <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                S_HALT: begin
                    if (resume) begin
                        halted <= 1'b0;
                        state  <= step_wrap ? S_IDLE : S_FETCH;
                        step_q <= step_wrap ? step_q : step_nxt;
                        if (step_wrap) err <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Bench for microcode_sequencer: directed microprograms with literal checks,
// then randomized opcodes/flags, all compared every cycle with a
// program-walking reference model.
module tb_microcode_sequencer;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_valid = 1'b0;
    logic [7:0]  opcode = '0;
    logic        ready;
    logic [11:0] rom_addr;
    logic [5:0]  rom_data = '0;
    logic [5:0]  uop;
    logic        uop_valid;
    logic        mt_done = 1'b0, ut_done = 1'b0, ft_done = 1'b0, dd_done = 1'b0, gpu_done = 1'b0;
    logic        halted;
    logic        resume = 1'b0;
    logic        err;

    logic [5:0]  rom [0:4095];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    always #5 clk = ~clk;

    // Synchronous ROM, one cycle of read latency.
    always @(posedge clk) rom_data <= rom[rom_addr];

    microcode_sequencer #(.OPCODE_W(8), .STEP_W(4), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .opcode(opcode), .ready(ready),
        .rom_addr(rom_addr), .rom_data(rom_data), .uop(uop), .uop_valid(uop_valid),
        .mt_done(mt_done), .ut_done(ut_done), .ft_done(ft_done), .dd_done(dd_done),
        .gpu_done(gpu_done), .halted(halted), .resume(resume), .err(err)
    );

    // ---------------- reference model ----------------
    // Tracks which program word is next and how many fetch cycles remain
    // before that word is acted upon.
    bit         m_busy, m_wait, m_halt;
    int         m_fetch_left, m_to;
    logic [7:0] m_op;
    logic [3:0] m_step;
    logic [5:0] m_kind;
    logic [5:0] e_uop;
    bit         e_uv, e_halted, e_err;

    function automatic bit released(input logic [5:0] k);
        case (k)
            6'd36:   return 1'b1;
            6'd41:   return mt_done;
            6'd42:   return ut_done;
            6'd43:   return ft_done;
            6'd44:   return dd_done;
            6'd45:   return gpu_done;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit wait_word(input logic [5:0] w);
        return (w == 6'd36) || (w >= 6'd41 && w <= 6'd45);
    endfunction

    task automatic m_next_step();
        if (m_step == 4'd15) begin
            e_err  = 1'b1;
            m_busy = 1'b0;
        end else begin
            m_step       = m_step + 4'd1;
            m_fetch_left = 1;
        end
    endtask

    always @(posedge clk) begin
        logic [5:0] w;
        cyc++;
        if (rst) begin
            m_busy = 0; m_wait = 0; m_halt = 0; m_fetch_left = 0; m_to = 0;
            m_op = '0; m_step = '0; m_kind = '0;
            e_uop = '0; e_uv = 0; e_halted = 0; e_err = 0;
        end else begin
            e_uv = 1'b0;
            if (!m_busy) begin
                if (op_valid) begin
                    m_busy = 1; m_op = opcode; m_step = '0; m_fetch_left = 1;
                end
            end else if (m_fetch_left > 0) begin
                m_fetch_left--;
            end else if (m_wait) begin
                if (released(m_kind)) begin
                    m_wait = 0;
                    m_next_step();
                end
`ifdef MICROSEQ_WAIT_TIMEOUT_EN
                else begin
                    m_to++;
                    if (m_to == TO) begin
                        m_wait = 0; m_busy = 0; e_err = 1;
                    end
                end
`endif
            end else if (m_halt) begin
                if (resume) begin
                    m_halt = 0; e_halted = 0;
                    m_next_step();
                end
            end else begin
                w = rom[{m_op, m_step}];
                if (w == 6'd0) begin
                    m_busy = 0;
                end else if (w == 6'd32) begin
                    e_uv = 1; e_uop = w; e_halted = 1; m_halt = 1;
                end else if (wait_word(w)) begin
                    m_wait = 1; m_kind = w; m_to = 0;
                end else if (w <= 6'd46) begin
                    e_uv = 1; e_uop = w;
                    m_next_step();
                end else begin
                    e_err = 1; m_busy = 0;
                end
            end
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        checks++;
        if (ready !== !m_busy || uop_valid !== e_uv || uop !== e_uop ||
            halted !== e_halted || err !== e_err || rom_addr !== {m_op, m_step}) begin
            errors++;
            $display("FAIL model cyc=%0d ready %b/%b uv %b/%b uop %0d/%0d halted %b/%b err %b/%b addr %h/%h",
                     cyc, ready, !m_busy, uop_valid, e_uv, uop, e_uop, halted, e_halted,
                     err, e_err, rom_addr, {m_op, m_step});
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic drive_op(input logic [7:0] op);
        op_valid = 1'b1;
        opcode   = op;
        tick();
        op_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [5:0] rand_word();
        int r;
        logic [5:0] w;
        r = $urandom_range(0, 99);
        if (r < 60) begin
            do w = 6'($urandom_range(1, 46)); while (w == 6'd32 || wait_word(w));
        end else if (r < 80) begin
            case ($urandom_range(0, 5))
                0: w = 6'd36; 1: w = 6'd41; 2: w = 6'd42;
                3: w = 6'd43; 4: w = 6'd44; default: w = 6'd45;
            endcase
        end else if (r < 85) w = 6'd32;
        else if (r < 95) w = 6'd0;
        else w = 6'($urandom_range(47, 63));
        return w;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int n;
        logic [7:0] picks [0:6];
        picks = '{8'h05, 8'h10, 8'h20, 8'h31, 8'h42, 8'h50, 8'h57};

        for (int a = 0; a < 4096; a++) rom[a] = 6'd0;
        rom[12'h050] = 6'd19; rom[12'h051] = 6'd33; rom[12'h052] = 6'd0;
        rom[12'h100] = 6'd39; rom[12'h101] = 6'd41; rom[12'h102] = 6'd2;  rom[12'h103] = 6'd0;
        rom[12'h200] = 6'd32; rom[12'h201] = 6'd8;  rom[12'h202] = 6'd0;
        for (int s = 0; s < 16; s++) rom[12'h300 + s] = 6'd9;
        rom[12'h310] = 6'd50;
        rom[12'h400] = 6'd45;
        rom[12'h410] = 6'd44;
        rom[12'h420] = 6'd36; rom[12'h421] = 6'd0;
        for (int o = 8'h50; o <= 8'h57; o++)
            for (int s = 0; s < 16; s++) rom[o * 16 + s] = rand_word();

        tick(); tick();
        rst = 1'b0;
        chk("reset_ready", 32'(ready), 1);
        chk("reset_uop", 32'(uop), 0);
        chk("reset_uv", 32'(uop_valid), 0);
        chk("reset_halted_err", 32'({halted, err}), 0);
        chk("reset_addr", 32'(rom_addr), 0);

        // Opcode 0x05: ALU_ADD then INC_PC, two cycles apart.
        drive_op(8'h05);
        tick(); tick();
        chk("op05_first_uop", 32'({uop_valid, uop}), 32'({1'b1, 6'd19}));
        tick();
        chk("op05_hold_uop", 32'({uop_valid, uop}), 32'({1'b0, 6'd19}));
        tick();
        chk("op05_second_uop", 32'({uop_valid, uop}), 32'({1'b1, 6'd33}));
        tick();
        chk("op05_busy", 32'(ready), 0);
        tick();
        chk("op05_ready", 32'(ready), 1);

        // Opcode 0x10: stall on WAIT_MT until mt_done.
        drive_op(8'h10);
        tick(); tick();
        chk("op10_start_mt", 32'({uop_valid, uop}), 32'({1'b1, 6'd39}));
        tick(); tick();
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (uop_valid) n++;
        end
        chk("op10_stall_issues", n, 0);
        chk("op10_stall_busy", 32'(ready), 0);
        mt_done = 1'b1;
        tick(); tick();
        chk("op10_no_early_issue", 32'(uop_valid), 0);
        tick();
        chk("op10_a_to_b", 32'({uop_valid, uop}), 32'({1'b1, 6'd2}));
        mt_done = 1'b0;
        tick(); tick();
        chk("op10_ready", 32'(ready), 1);

        // Opcode 0x20: HLT_CLK, held halt, resume.
        drive_op(8'h20);
        tick(); tick();
        chk("op20_hlt_issue", 32'({uop_valid, uop, halted}), 32'({1'b1, 6'd32, 1'b1}));
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (halted) n++;
        end
        chk("op20_halt_held", n, 20);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        chk("op20_resumed", 32'(halted), 0);
        tick(); tick();
        chk("op20_b_to_a", 32'({uop_valid, uop}), 32'({1'b1, 6'd8}));
        tick(); tick();
        chk("op20_ready", 32'(ready), 1);

        // Opcode 0x30: 16 steps and no end marker.
        drive_op(8'h30);
        n = 0;
        for (int i = 0; i < 80 && !ready; i++) begin
            tick();
            if (uop_valid) n++;
        end
        chk("op30_issues", n, 16);
        chk("op30_err_ready", 32'({err, ready}), 32'(2'b11));

        // Illegal ROM word after a clean reset, then err does not block.
        do_reset();
        chk("clear_err", 32'(err), 0);
        drive_op(8'h31);
        n = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (uop_valid) n++;
        end
        chk("op31_no_issue", n, 0);
        chk("op31_err_ready", 32'({err, ready}), 32'(2'b11));
        drive_op(8'h05);
        tick(); tick();
        chk("after_err_issue", 32'({uop_valid, uop}), 32'({1'b1, 6'd19}));
        tick(); tick(); tick(); tick();

        // Reset while waiting on gpu_done, with an opcode offered alongside.
        drive_op(8'h40);
        tick(); tick(); tick(); tick();
        chk("gpu_wait_busy", 32'(ready), 0);
        rst = 1'b1; op_valid = 1'b1; opcode = 8'h05;
        tick();
        rst = 1'b0; op_valid = 1'b0;
        chk("rst_wait_outs", 32'({ready, uop, halted, err, uop_valid}), 32'({1'b1, 6'd0, 3'b000}));
        chk("rst_wait_addr", 32'(rom_addr), 0);
        tick();
        chk("rst_op_ignored", 32'({ready, uop_valid}), 32'(2'b10));

        // WAIT_DD with dd_done held low.
        drive_op(8'h41);
`ifdef MICROSEQ_WAIT_TIMEOUT_EN
        for (int i = 0; i < 9; i++) tick();
        chk("dd_wait_before_timeout", 32'(ready), 0);
        tick();
        chk("dd_timeout", 32'({err, ready}), 32'(2'b11));
`else
        for (int i = 0; i < 100; i++) tick();
        chk("dd_still_waiting", 32'({ready, err}), 0);
`endif
        do_reset();

        // WAIT_CYCLE exits after one cycle.
        drive_op(8'h42);
        tick(); tick(); tick(); tick();
        chk("wait_cycle_busy", 32'(ready), 0);
        tick();
        chk("wait_cycle_done", 32'(ready), 1);

        // Randomized opcodes, flags, resume and occasional reset.
        for (int i = 0; i < 4000; i++) begin
            rst      = ($urandom_range(0, 199) == 0);
            op_valid = 1'($urandom_range(0, 1));
            opcode   = ($urandom_range(0, 9) == 0) ? 8'($urandom) : picks[$urandom_range(0, 6)];
            mt_done  = ($urandom_range(0, 3) == 0);
            ut_done  = ($urandom_range(0, 3) == 0);
            ft_done  = ($urandom_range(0, 3) == 0);
            dd_done  = ($urandom_range(0, 3) == 0);
            gpu_done = ($urandom_range(0, 3) == 0);
            resume   = ($urandom_range(0, 4) == 0);
            tick();
        end
        rst = 1'b0; op_valid = 1'b0; resume = 1'b0;
        {mt_done, ut_done, ft_done, dd_done, gpu_done} = '0;
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
